// File: rtl/oh_logic_demux_reg.sv
// Registered one-hot demultiplexer with valid/ready handshakes.
// One 1-entry slot per output channel; illegal selects are dropped and counted.
module oh_logic_demux_reg #(
    parameter int NUM   = 4,
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [NUM-1:0]   in_oh_sel_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic [NUM-1:0]   out_valid_o,
    input  logic [NUM-1:0]   out_ready_i,
    output logic [WIDTH-1:0] out_data_o [NUM-1:0],
    output logic             sel_err_o,
    output logic [CNTW-1:0]  sel_err_cnt_o
);

    logic           legal;
    logic [NUM-1:0] slot_free;
    logic [NUM-1:0] acc;
    logic           illegal_beat;

    // exactly one bit set: nonzero and clearing the lowest bit leaves zero
    assign legal = (in_oh_sel_i != '0) &&
                   ((in_oh_sel_i & (in_oh_sel_i - NUM'(1))) == '0);

    assign slot_free    = ~out_valid_o | out_ready_i;
    assign in_ready_o   = legal ? |(in_oh_sel_i & slot_free) : 1'b1;
    assign acc          = {NUM{in_valid_i & legal & in_ready_o}} & in_oh_sel_i;
    assign illegal_beat = in_valid_i & ~legal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= '0;
            for (int j = 0; j < NUM; j++) begin
                out_data_o[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM; j++) begin
                if (acc[j]) begin
                    out_data_o[j]  <= in_data_i;
                    out_valid_o[j] <= 1'b1;
                end else if (out_valid_o[j] && out_ready_i[j]) begin
                    out_valid_o[j] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_err_o     <= 1'b0;
            sel_err_cnt_o <= '0;
        end else begin
            sel_err_o <= illegal_beat;
            if (illegal_beat && (sel_err_cnt_o != '1)) begin
                sel_err_cnt_o <= sel_err_cnt_o + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_oh_logic_demux_reg.sv
// Directed bench for oh_logic_demux_reg with a per-channel scoreboard.
// Runs with CNTW=2 so counter saturation is reachable.
module tb_oh_logic_demux_reg;

    localparam int NUM   = 4;
    localparam int WIDTH = 32;
    localparam int CNTW  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [NUM-1:0]   in_sel;
    logic [WIDTH-1:0] in_data;
    logic [NUM-1:0]   out_valid;
    logic [NUM-1:0]   out_ready;
    logic [WIDTH-1:0] out_data [NUM-1:0];
    logic             sel_err;
    logic [CNTW-1:0]  sel_err_cnt;

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] sb [NUM][$];

    always #5 clk = ~clk;

    oh_logic_demux_reg #(.NUM(NUM), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_oh_sel_i  (in_sel),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .sel_err_o    (sel_err),
        .sel_err_cnt_o(sel_err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are sampled mid-cycle; they complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM; j++) sb[j].delete();
        end else begin
            for (int j = 0; j < NUM; j++) begin
                if (out_valid[j] && out_ready[j]) begin
                    if (sb[j].size() == 0) begin
                        chk("sb_unexpected_out", {32'd0, out_data[j]}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("sb_data", {32'd0, out_data[j]}, {32'd0, sb[j].pop_front()});
                    end
                end
            end
            if (in_valid && in_ready && $countones(in_sel) == 1) begin
                for (int j = 0; j < NUM; j++) begin
                    if (in_sel[j]) sb[j].push_back(in_data);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        cyc();
        cyc();
        chk("rst_valid", {60'd0, out_valid}, 64'h0);
        for (int j = 0; j < NUM; j++) chk("rst_data", {32'd0, out_data[j]}, 64'h0);
        chk("rst_err", {63'd0, sel_err}, 64'h0);
        chk("rst_cnt", {62'd0, sel_err_cnt}, 64'h0);
        rst = 1'b0;
        cyc();

        // 1: single beat into ch2, then stall for 10 cycles
        in_valid = 1'b1;
        in_sel   = 4'b0100;
        in_data  = 32'hA5A5_A5A5;
        chk("t1_ready", {63'd0, in_ready}, 64'h1);
        cyc();
        in_valid = 1'b0;
        chk("t1_valid", {60'd0, out_valid}, 64'h4);
        chk("t1_data", {32'd0, out_data[2]}, 64'hA5A5_A5A5);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t1_hold_valid", {60'd0, out_valid}, 64'h4);
            chk("t1_hold_data", {32'd0, out_data[2]}, 64'hA5A5_A5A5);
        end

        // 2: full ch2 blocks, ch0 still accepts in the same cycle
        in_valid = 1'b1;
        in_sel   = 4'b0100;
        in_data  = 32'h0000_1234;
        #1;
        chk("t2_blocked", {63'd0, in_ready}, 64'h0);
        in_sel  = 4'b0001;
        in_data = 32'h0000_C0DE;
        #1;
        chk("t2_free", {63'd0, in_ready}, 64'h1);
        cyc();
        in_valid = 1'b0;
        chk("t2_valid", {60'd0, out_valid}, 64'h5);
        chk("t2_data0", {32'd0, out_data[0]}, 64'hC0DE);
        chk("t2_data2", {32'd0, out_data[2]}, 64'hA5A5_A5A5);
        out_ready = 4'b0101;
        cyc();
        chk("t2_drained", {60'd0, out_valid}, 64'h0);
        chk("t2_data0_kept", {32'd0, out_data[0]}, 64'hC0DE);
        out_ready = '0;

        // 3: back-to-back streaming through ch1
        out_ready = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 4'b0010;
            in_data  = WIDTH'(i);
            chk("t3_ready", {63'd0, in_ready}, 64'h1);
            cyc();
            chk("t3_valid", {60'd0, out_valid}, 64'h2);
            chk("t3_data", {32'd0, out_data[1]}, 64'(i));
        end
        in_valid = 1'b0;
        cyc();
        chk("t3_empty", {60'd0, out_valid}, 64'h0);
        out_ready = '0;
        for (int j = 0; j < NUM; j++) chk("t3_sb_left", 64'(sb[j].size()), 64'h0);

        // 4: zero-hot and two-hot selects are dropped and counted
        in_valid = 1'b1;
        in_sel   = 4'b0000;
        in_data  = 32'hBAD0_0000;
        chk("t4_ready0", {63'd0, in_ready}, 64'h1);
        cyc();
        chk("t4_err1", {63'd0, sel_err}, 64'h1);
        chk("t4_cnt1", {62'd0, sel_err_cnt}, 64'h1);
        in_sel  = 4'b0110;
        in_data = 32'hBAD0_0001;
        chk("t4_ready2", {63'd0, in_ready}, 64'h1);
        cyc();
        in_valid = 1'b0;
        chk("t4_err2", {63'd0, sel_err}, 64'h1);
        cyc();
        chk("t4_err_low", {63'd0, sel_err}, 64'h0);
        chk("t4_cnt2", {62'd0, sel_err_cnt}, 64'h2);
        chk("t4_no_valid", {60'd0, out_valid}, 64'h0);

        // 5: counter saturates at 3
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_sel   = 4'b1111;
            in_data  = $urandom;
            cyc();
            chk("t5_cnt", {62'd0, sel_err_cnt}, (2 + k > 3) ? 64'h3 : 64'(2 + k));
        end
        in_valid = 1'b0;
        cyc();
        chk("t5_cnt_final", {62'd0, sel_err_cnt}, 64'h3);
        chk("t5_no_valid", {60'd0, out_valid}, 64'h0);

        // 6: reset wins over a concurrent legal beat
        in_valid = 1'b1;
        in_sel   = 4'b1000;
        in_data  = 32'h1111_2222;
        cyc();
        in_sel  = 4'b0010;
        in_data = 32'h3333_4444;
        cyc();
        in_valid = 1'b0;
        chk("t6_full", {60'd0, out_valid}, 64'hA);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sel   = 4'b0001;
        in_data  = 32'hDEAD_BEEF;
        cyc();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("t6_valid", {60'd0, out_valid}, 64'h0);
        for (int j = 0; j < NUM; j++) chk("t6_data", {32'd0, out_data[j]}, 64'h0);
        chk("t6_err", {63'd0, sel_err}, 64'h0);
        chk("t6_cnt", {62'd0, sel_err_cnt}, 64'h0);
        cyc();
        chk("t6_not_captured", {60'd0, out_valid}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
